// File: rtl/ofmap_pkg.sv
// Shared constants and FSM encoding for the ofmap readout path.
package ofmap_pkg;

  localparam int OFMAP_ADDR_WIDTH = 12;
  localparam int OFMAP_OUT_WIDTH  = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/ofmap_bit_packer.sv
// Insert register that assembles 1-bit BRAM reads into an output word.
module ofmap_bit_packer #(
  parameter int WIDTH = ofmap_pkg::OFMAP_OUT_WIDTH,
  parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_idx,
  input  logic             i_wr_bit,
  output logic [WIDTH-1:0] o_word
);

  logic [WIDTH-1:0] r_word;

  // NOTE: this register feeds m_data directly, so it takes the async reset
  // like every other output register; clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (i_clr) begin
      r_word <= '0;
    end else if (i_wr_en) begin
      r_word[i_wr_idx] <= i_wr_bit;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/ofmap_reader.sv
// Reads a finished 1-bit ofmap out of BRAM and streams it as packed words.
module ofmap_reader
  import ofmap_pkg::*;
#(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = OFMAP_ADDR_WIDTH,
  parameter int OUT_WIDTH              = OFMAP_OUT_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH:0]   num_pixels,
  output logic                              bram_en,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] bram_addr,
  input  logic                              bram_rdata,
  output logic [OUT_WIDTH-1:0]              m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic                              busy,
  output logic                              done
);

  localparam int AW = OFMAPS_BRAM_ADDR_WIDTH;
  localparam int CW = AW + 1;
  localparam int IW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int LW = $clog2(OUT_WIDTH + 1);
  localparam logic [CW-1:0] MAX_N  = {1'b1, {AW{1'b0}}};
  localparam logic [CW-1:0] WORD_N = CW'(OUT_WIDTH);

  state_t          r_state;
  logic [CW-1:0]   r_n;
  logic [CW-1:0]   r_issued;
  logic [LW-1:0]   r_word_left;
  logic            r_bram_en;
  logic [AW-1:0]   r_bram_addr;
  logic            r_rd_vld;
  logic [IW-1:0]   r_rd_idx;
  logic            r_m_valid;
  logic            r_m_last;
  logic            r_busy;
  logic            r_done;

  logic [CW-1:0]   w_n_clamp;
  logic            w_pack_clr;

  function automatic logic [LW-1:0] word_len(input logic [CW-1:0] rem);
    if (rem > WORD_N) return LW'(OUT_WIDTH);
    else              return LW'(rem);
  endfunction

  assign w_n_clamp  = (num_pixels > MAX_N) ? MAX_N : num_pixels;
  assign w_pack_clr = ((r_state == IDLE) && start) || ((r_state == SEND) && m_ready);

  // NOTE: all state and outputs are non-blocking so every register samples
  // pre-edge values; r_rd_vld/r_rd_idx model the 1-cycle BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_issued    <= '0;
      r_word_left <= '0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_idx    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_vld <= r_bram_en;
      r_rd_idx <= r_bram_addr[IW-1:0];
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n      <= w_n_clamp;
            r_issued <= '0;
            r_busy   <= 1'b1;
            if (w_n_clamp != '0) begin
              r_state     <= READ;
              r_bram_en   <= 1'b1;
              r_bram_addr <= '0;
              r_word_left <= word_len(w_n_clamp);
            end else begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          r_issued <= r_issued + CW'(1);
          if (r_word_left == LW'(1)) begin
            r_bram_en <= 1'b0;
            r_state   <= WAIT;
          end else begin
            r_bram_addr <= r_bram_addr + AW'(1);
            r_word_left <= r_word_left - LW'(1);
          end
        end
        WAIT: begin
          r_state   <= SEND;
          r_m_valid <= 1'b1;
          r_m_last  <= (r_issued == r_n);
        end
        SEND: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state     <= READ;
              r_bram_en   <= 1'b1;
              r_bram_addr <= r_issued[AW-1:0];
              r_word_left <= word_len(r_n - r_issued);
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ofmap_bit_packer #(
    .WIDTH (OUT_WIDTH),
    .IW    (IW)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_pack_clr),
    .i_wr_en  (r_rd_vld),
    .i_wr_idx (r_rd_idx),
    .i_wr_bit (bram_rdata),
    .o_word   (m_data)
  );

  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ofmap_reader.sv
// Scoreboard bench for ofmap_reader: directed readouts against a 1-bit BRAM model.
module tb_ofmap_reader;

  localparam int AW = 12;
  localparam int OW = 32;

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_pixels = '0;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic          bram_rdata = 1'b0;
  logic [OW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          done;

  logic          mem [0:(1<<AW)-1];
  word_t         sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt, done_cnt, valid_cnt, xfer_cnt, exp_addr;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] held_data;
  logic          held_last;

  ofmap_reader #(
    .OFMAPS_BRAM_ADDR_WIDTH (AW),
    .OUT_WIDTH              (OW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_pixels (num_pixels),
    .bram_en    (bram_en),
    .bram_addr  (bram_addr),
    .bram_rdata (bram_rdata),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: address sequence, stall stability and scoreboard compare.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bram_en) begin
        en_cnt++;
        check("bram_addr", OW'(bram_addr), OW'(exp_addr));
        exp_addr++;
      end
      if (done) done_cnt++;
      if (m_valid) valid_cnt++;
      if (stall_prev) begin
        check("stall_valid", OW'(m_valid), OW'(1));
        check("stall_data", m_data, held_data);
        check("stall_last", OW'(m_last), OW'(held_last));
      end
      stall_prev = m_valid && !m_ready;
      held_data  = m_data;
      held_last  = m_last;
      if (m_valid && m_ready) begin
        word_t e;
        xfer_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected no word", m_data, m_last);
        end else begin
          e = sb.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", OW'(m_last), OW'(e.last));
        end
      end
    end
  end

  task automatic clear_counts();
    en_cnt = 0; done_cnt = 0; valid_cnt = 0; xfer_cnt = 0;
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < (1 << AW); i++) begin
      case (mode)
        0:       mem[i] = 1'b1;
        1:       mem[i] = i[0];
        default: mem[i] = ((i % 3) == 0);
      endcase
    end
  endtask

  task automatic push(input logic [OW-1:0] d, input logic l);
    word_t w;
    w.data = d;
    w.last = l;
    sb.push_back(w);
  endtask

  // Returns positioned #1 after the edge that samples start.
  task automatic start_readout(input int n);
    @(posedge clk); #1;
    exp_addr   = 0;
    num_pixels = (AW+1)'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done after %0d cycles expected done", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    fill_mem(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_bram_en", OW'(bram_en), 0);
    check("rst_m_valid", OW'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", OW'(busy), 0);
    check("rst_done", OW'(done), 0);
    rst_n = 1'b1;

    // N=64, all ones
    clear_counts();
    push(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b1);
    start_readout(64);
    wait_done("n64", 200);
    check("n64_en_cycles", OW'(en_cnt), 64);
    check("n64_done_cnt", OW'(done_cnt), 1);
    check("n64_words", OW'(xfer_cnt), 2);
    check("n64_sb_empty", OW'(sb.size()), 0);

    // N=40, bit i = i[0]
    fill_mem(1);
    clear_counts();
    push(32'hAAAA_AAAA, 1'b0);
    push(32'h0000_00AA, 1'b1);
    start_readout(40);
    wait_done("n40", 200);
    check("n40_words", OW'(xfer_cnt), 2);
    check("n40_sb_empty", OW'(sb.size()), 0);

    // N=32 with 5-cycle stall; latency t+n+1
    fill_mem(2);
    clear_counts();
    m_ready = 1'b0;
    push(32'h4924_9249, 1'b1);
    start_readout(32);
    check("n32_busy", OW'(busy), 1);
    cyc = 1;
    while (!m_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("n32_latency", OW'(cyc), 34);
    repeat (5) @(posedge clk);
    #1;
    check("n32_valid_held", OW'(m_valid), 1);
    check("n32_no_xfer_stall", OW'(xfer_cnt), 0);
    m_ready = 1'b1;
    wait_done("n32", 50);
    check("n32_words", OW'(xfer_cnt), 1);
    check("n32_sb_empty", OW'(sb.size()), 0);

    // N=0
    clear_counts();
    start_readout(0);
    check("n0_done_pulse", OW'(done), 1);
    @(posedge clk); #1;
    check("n0_done_low", OW'(done), 0);
    check("n0_busy_low", OW'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("n0_en_cycles", OW'(en_cnt), 0);
    check("n0_valid_cycles", OW'(valid_cnt), 0);

    // Second start while busy is ignored
    fill_mem(0);
    clear_counts();
    push(32'hFFFF_FFFF, 1'b0);
    push(32'h0000_00FF, 1'b1);
    start_readout(40);
    repeat (5) @(posedge clk);
    #1;
    num_pixels = 13'd64;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("dbl", 200);
    repeat (10) @(posedge clk);
    #1;
    check("dbl_words", OW'(xfer_cnt), 2);
    check("dbl_done_cnt", OW'(done_cnt), 1);
    check("dbl_en_cycles", OW'(en_cnt), 40);

    // num_pixels above BRAM depth clamps to 4096
    clear_counts();
    for (int w = 0; w < 127; w++) push(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b1);
    start_readout(8191);
    wait_done("clamp", 6000);
    check("clamp_en_cycles", OW'(en_cnt), 4096);
    check("clamp_words", OW'(xfer_cnt), 128);
    check("clamp_sb_empty", OW'(sb.size()), 0);

    // Reset during READ of a 4096-pixel readout
    clear_counts();
    start_readout(4096);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bram_en", OW'(bram_en), 0);
    check("mid_rst_bram_addr", OW'(bram_addr), 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_m_valid", OW'(m_valid), 0);
    check("mid_rst_m_last", OW'(m_last), 0);
    check("mid_rst_busy", OW'(busy), 0);
    check("mid_rst_done", OW'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_counts();
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_busy", OW'(busy), 0);
    check("post_rst_en_cycles", OW'(en_cnt), 0);
    push(32'h0000_0001, 1'b1);
    start_readout(1);
    wait_done("n1", 50);
    check("n1_words", OW'(xfer_cnt), 1);
    check("n1_sb_empty", OW'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
